// File: rtl/effect_pkg.sv
// Shared types and default sizing for the effect frame scheduler and its watchdog.
package effect_pkg;

    localparam int ADDR_WIDTH    = 10;
    localparam int DEPTH_WIDTH   = 8;
    localparam int DEPTH_MAX     = 128;
    localparam int DRAIN_TIMEOUT = 16;
    localparam int CNT_WIDTH     = 16;
    localparam int WD_WIDTH      = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/effect_sched_watchdog.sv
// DRAIN watchdog: counts enabled cycles and flags the cycle on which the budget runs out.
module effect_sched_watchdog #(
    parameter int TIMEOUT = effect_pkg::DRAIN_TIMEOUT,
    parameter int W       = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Fires on the TIMEOUT-th enabled cycle, so the owner leaves after exactly TIMEOUT cycles.
    assign expired = count_en && !clear && (cnt_q == W'(TIMEOUT - 1));

    // NOTE: sequential state is written only with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/effect_frame_scheduler.sv
// Frame-level controller: accepts a captured frame, runs the modulation engine for one
// frame length, waits for its done flag under a watchdog, then holds the output RAM.
module effect_frame_scheduler #(
    parameter int ADDR_WIDTH    = effect_pkg::ADDR_WIDTH,
    parameter int DEPTH_WIDTH   = effect_pkg::DEPTH_WIDTH,
    parameter int DEPTH_MAX     = effect_pkg::DEPTH_MAX,
    parameter int DRAIN_TIMEOUT = effect_pkg::DRAIN_TIMEOUT,
    parameter int CNT_WIDTH     = effect_pkg::CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [ADDR_WIDTH-1:0]  in_len,
    output logic                   in_ack,
    input  logic [DEPTH_WIDTH-1:0] depth_cfg,
    output logic                   eng_en,
    output logic [ADDR_WIDTH-1:0]  eng_len_max,
    output logic [DEPTH_WIDTH-1:0] eng_depth,
    input  logic                   eng_done,
    output logic                   out_valid,
    output logic [ADDR_WIDTH-1:0]  out_len,
    input  logic                   out_release,
    output logic                   busy,
    output logic                   err_timeout,
    input  logic                   err_clr,
    output logic [CNT_WIDTH-1:0]   frame_cnt
);

    import effect_pkg::*;

    localparam logic [DEPTH_WIDTH-1:0] DEPTH_CLAMP = DEPTH_WIDTH'(DEPTH_MAX);

    state_t                 state_q,       state_d;
    logic                   in_ack_q,      in_ack_d;
    logic                   eng_en_q,      eng_en_d;
    logic [ADDR_WIDTH-1:0]  eng_len_max_q, eng_len_max_d;
    logic [DEPTH_WIDTH-1:0] eng_depth_q,   eng_depth_d;
    logic                   out_valid_q,   out_valid_d;
    logic [ADDR_WIDTH-1:0]  out_len_q,     out_len_d;
    logic                   busy_q,        busy_d;
    logic                   err_q,         err_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q,   frame_cnt_d;
    logic [ADDR_WIDTH-1:0]  run_cnt_q,     run_cnt_d;
    logic                   done_q,        done_d;
    logic                   err_set;
    logic                   wd_expired;

    effect_sched_watchdog #(
        .TIMEOUT (DRAIN_TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state_q != DRAIN),
        .count_en (state_q == DRAIN),
        .expired  (wd_expired)
    );

    // NOTE: every _d gets a default before the case, so no path through this block infers a latch.
    always_comb begin
        state_d       = state_q;
        in_ack_d      = 1'b0;
        eng_en_d      = 1'b0;
        eng_len_max_d = eng_len_max_q;
        eng_depth_d   = eng_depth_q;
        out_len_d     = out_len_q;
        frame_cnt_d   = frame_cnt_q;
        run_cnt_d     = run_cnt_q;
        done_d        = done_q;
        err_set       = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                in_ack_d      = 1'b1;
                eng_len_max_d = in_len;
                out_len_d     = in_len;
                eng_depth_d   = (depth_cfg > DEPTH_CLAMP) ? DEPTH_CLAMP : depth_cfg;
                run_cnt_d     = '0;
                done_d        = 1'b0;
                state_d       = RUN;
            end
            RUN: begin
                // First RUN cycle only raises eng_en; the counter advances once eng_en is visible.
                if (eng_en_q && (run_cnt_q == eng_len_max_q)) begin
                    state_d = DRAIN;
                end else begin
                    eng_en_d = 1'b1;
                    if (eng_en_q) begin
                        run_cnt_d = run_cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (done_q) begin
                    state_d = DONE;
                end else if (wd_expired) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (out_release) begin
                    frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The engine flags done continuously while idle, so only RUN/DRAIN cycles count.
        if (((state_q == RUN) || (state_q == DRAIN)) && eng_done) begin
            done_d = 1'b1;
        end

        err_d = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end

        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            in_ack_q      <= 1'b0;
            eng_en_q      <= 1'b0;
            eng_len_max_q <= '0;
            eng_depth_q   <= '0;
            out_valid_q   <= 1'b0;
            out_len_q     <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            frame_cnt_q   <= '0;
            run_cnt_q     <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_ack_q      <= in_ack_d;
            eng_en_q      <= eng_en_d;
            eng_len_max_q <= eng_len_max_d;
            eng_depth_q   <= eng_depth_d;
            out_valid_q   <= out_valid_d;
            out_len_q     <= out_len_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            frame_cnt_q   <= frame_cnt_d;
            run_cnt_q     <= run_cnt_d;
            done_q        <= done_d;
        end
    end

    assign in_ack      = in_ack_q;
    assign eng_en      = eng_en_q;
    assign eng_len_max = eng_len_max_q;
    assign eng_depth   = eng_depth_q;
    assign out_valid   = out_valid_q;
    assign out_len     = out_len_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/effect_frame_scheduler.md
Name: effect_frame_scheduler

Overview:
- Frame-level controller for the sine-amplitude-modulation effect engine and its output RAM.
- Accepts a captured-frame handshake from the capture buffer and shadows the depth setting at the frame boundary.
- Drives the engine enable for exactly one frame length, then waits for the engine done flag with a watchdog.
- Holds the output RAM for the playback reader until released; one frame in flight at a time.

Parameters:
ADDR_WIDTH, 10, frame address width (max address 1023)
DEPTH_WIDTH, 8, modulation depth width
DEPTH_MAX, 128, depth clamp value (engine computes 128-depth)
DRAIN_TIMEOUT, 16, cycles allowed in DRAIN for engine done before abort
CNT_WIDTH, 16, completed-frame counter width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  captured frame ready
in_len  in  ADDR_WIDTH  last sample address of frame (samples = in_len+1)
in_ack  out  1  one-cycle pulse: frame accepted
depth_cfg  in  DEPTH_WIDTH  requested modulation depth (live register value)
eng_en  out  1  engine write enable (frame run)
eng_len_max  out  ADDR_WIDTH  engine max address
eng_depth  out  DEPTH_WIDTH  engine depth, frame-stable
eng_done  in  1  engine end-of-frame flag (pulse)
out_valid  out  1  output RAM holds a finished frame
out_len  out  ADDR_WIDTH  last valid address of finished frame
out_release  in  1  reader finished with output RAM
busy  out  1  state != IDLE
err_timeout  out  1  sticky: engine done missing
err_clr  in  1  clears err_timeout
frame_cnt  out  CNT_WIDTH  completed frames, wraps

Behaviour:
- Single clock. Reset is synchronous and active-low on clk: rst_n low at an edge forces IDLE. At that edge all outputs go to 0 (in_ack, eng_en, eng_len_max, eng_depth, out_valid, out_len, busy, err_timeout, frame_cnt).
- Reset mid-operation drops the frame; eng_en is low at the next edge.
- All outputs are registered.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE: on in_valid=1, go to LOAD.
- LOAD (1 cycle):
  - in_ack=1.
  - eng_len_max<=in_len; out_len<=in_len.
  - eng_depth<=min(depth_cfg, DEPTH_MAX).
  - Clear run counter and done latch.
  - Go to RUN.
- RUN:
  - eng_en=1 for exactly in_len+1 cycles; in_len=0 gives 1 cycle.
  - The counter increments each cycle; when it equals eng_len_max, go to DRAIN and drop eng_en at that transition.
- DRAIN:
  - eng_en=0; the watchdog counts cycles.
  - When the done latch is set, go to DONE.
  - If the watchdog reaches DRAIN_TIMEOUT with the latch clear: err_timeout<=1, go to IDLE, no out_valid.
- Done latch:
  - Set by eng_done=1 in any RUN or DRAIN cycle.
  - eng_done in IDLE, LOAD or DONE is ignored. The engine flags continuously when its max address is 0 and it is idle.
- DONE:
  - out_valid=1.
  - On out_release=1: go to IDLE, out_valid<=0, frame_cnt<=frame_cnt+1 (wraps).
- out_release outside DONE is ignored.
- in_valid outside IDLE is not acknowledged; the source holds it.
- Back-to-back frames: DONE→IDLE→LOAD gives a minimum 1 IDLE cycle between frames.
- Latency: in_valid sampled at edge T gives in_ack at T+1, first eng_en at T+2, last eng_en at T+2+in_len.
- eng_depth and eng_len_max are stable from LOAD until the next LOAD. depth_cfg changes mid-frame take effect next frame.
- err_timeout: set has priority over simultaneous err_clr; cleared only by err_clr or reset.
- busy=1 in LOAD, RUN, DRAIN, DONE.

Decomposition:
- Shared package effect_pkg:
  - State enum (IDLE, LOAD, RUN, DRAIN, DONE).
  - ADDR_WIDTH, DEPTH_WIDTH, DEPTH_MAX constants.
  - Watchdog counter width, $clog2(DRAIN_TIMEOUT+1).
- One sub-module: effect_sched_watchdog (clear/count/expire). The FSM, run counter and latches stay in the top module.

Test Plan:
- in_len=9, depth_cfg=64, eng_done 4 cycles after last eng_en, out_release 5 cycles after out_valid -> in_ack at T+1; eng_en high 10 cycles; eng_depth=64; out_len=9; frame_cnt=1; busy low after release.
- in_len=0 with eng_done stuck high while IDLE -> no state change in IDLE; after in_valid, eng_en high 1 cycle; DONE reached; frame_cnt increments once per release.
- depth_cfg=200 -> eng_depth=128. depth_cfg changed to 10 mid-RUN -> eng_depth stays 128 until next LOAD.
- eng_done never asserted, DRAIN_TIMEOUT=16 -> err_timeout=1 after 16 DRAIN cycles; out_valid never high; err_clr then err_timeout=0; set+clr same cycle -> stays 1.
- in_valid held high during RUN/DONE; out_release pulsed during RUN -> no extra in_ack; frame not released early; second frame acked 2 cycles after release.
- rst_n low for 1 cycle mid-RUN (in_len=100) -> eng_en=0 and all outputs 0 at the next edge; next frame runs normally.
